// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel post-filter controller: view-mode encoding,
// the shadowed host-configuration record and reset defaults.
package sobel_pkg;

  localparam int         SOBEL_CNT_W       = 12;
  localparam logic [7:0] SOBEL_DEFAULT_THR = 8'd64;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_MAG  = 2'd1,
    MODE_THR  = 2'd2,
    MODE_OVL  = 2'd3
  } mode_t;

  typedef struct packed {
    mode_t      mode;
    logic [7:0] thr;
    logic [3:0] border;
  } cfg_t;

  function automatic logic [23:0] gray3(input logic [7:0] s);
    return {s, s, s};
  endfunction

endpackage

// File: rtl/sobel_pos_tracker.sv
// Pixel/line position tracker: de/vsync edge detect, x/y counters, measured frame dimensions.
// Latency: geometry for the current pixel is combinational; measurements register on line/frame edges.
// Backpressure: none, free-running video stream.
module sobel_pos_tracker
  import sobel_pkg::*;
#(
  parameter int CNT_W = SOBEL_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             de_in,
  input  logic             v_sync_in,
  output logic             frame_start,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic [CNT_W-1:0] lim_height,
  output logic             lim_valid,
  output logic [CNT_W-1:0] meas_width,
  output logic [CNT_W-1:0] meas_height,
  output logic [15:0]      frame_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic             de_prev;
  logic             vs_prev;
  logic             de_fall;
  logic             dims_valid;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic [CNT_W-1:0] y_next;

  // A frame start on the same clock as a pixel wins: that pixel already sees y=0
  // and the freshly latched frame dimensions.
  always_comb begin
    frame_start = v_sync_in & ~vs_prev;
    de_fall     = de_prev & ~de_in;
    pix_x       = x;
    pix_y       = frame_start ? '0 : y;
    lim_height  = frame_start ? y : meas_height;
    lim_valid   = frame_start ? ((meas_width != '0) && (y != '0)) : dims_valid;
    y_next      = pix_y;
    if (de_fall && (pix_y != CNT_MAX)) y_next = pix_y + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      dims_valid  <= 1'b0;
      x           <= '0;
      y           <= '0;
      meas_width  <= '0;
      meas_height <= '0;
      frame_cnt   <= 16'd0;
    end else begin
      de_prev <= de_in;
      vs_prev <= v_sync_in;
      y       <= y_next;
      if (de_in) begin
        if (x != CNT_MAX) x <= x + CNT_ONE;
      end else begin
        x <= '0;
      end
      if (de_fall) meas_width <= x;
      if (frame_start) begin
        meas_height <= y;
        frame_cnt   <= frame_cnt + 16'd1;
        dims_valid  <= lim_valid;
      end
    end
  end

endmodule

// File: rtl/sobel_ctrl.sv
// Sobel post-filter controller: border blanking, view-mode select, edge threshold; SOBEL_CTRL_STATS_EN adds an edge counter.
// Latency: exactly 1 clk for pixel and all syncs; host config takes effect at the next vsync rise.
// Backpressure: none, output follows the input stream cycle for cycle.
module sobel_ctrl
  import sobel_pkg::*;
#(
  parameter int         CNT_W       = SOBEL_CNT_W,
  parameter logic [7:0] DEFAULT_THR = SOBEL_DEFAULT_THR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             de_in,
  input  logic             h_sync_in,
  input  logic             v_sync_in,
  input  logic [23:0]      pixel_in,
  input  logic [1:0]       cfg_mode,
  input  logic [7:0]       cfg_thr,
  input  logic [3:0]       cfg_border,
  output logic             de_out,
  output logic             h_sync_out,
  output logic             v_sync_out,
  output logic [23:0]      pixel_out,
  output logic [CNT_W-1:0] meas_width,
  output logic [CNT_W-1:0] meas_height,
  output logic [15:0]      frame_cnt,
  output logic [23:0]      edge_count
);

  logic             frame_start;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic [CNT_W-1:0] lim_height;
  logic             lim_valid;

  sobel_pos_tracker #(.CNT_W(CNT_W)) u_pos (
    .clk         (clk),
    .rst         (rst),
    .de_in       (de_in),
    .v_sync_in   (v_sync_in),
    .frame_start (frame_start),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .lim_height  (lim_height),
    .lim_valid   (lim_valid),
    .meas_width  (meas_width),
    .meas_height (meas_height),
    .frame_cnt   (frame_cnt)
  );

  cfg_t shadow;
  cfg_t cfg_in;
  cfg_t cfg_eff;

  always_comb begin
    cfg_in.mode   = mode_t'(cfg_mode);
    cfg_in.thr    = cfg_thr;
    cfg_in.border = cfg_border;
    cfg_eff       = frame_start ? cfg_in : shadow;
  end

  // One extra bit lets x+B be compared against the width without underflow
  // when the measured width is smaller than the border.
  logic [CNT_W:0] b_ext;
  logic [CNT_W:0] x_ext;
  logic [CNT_W:0] y_ext;
  logic [CNT_W:0] w_ext;
  logic [CNT_W:0] h_ext;
  logic           lead;
  logic           trail;
  logic           border;

  always_comb begin
    b_ext  = {{(CNT_W-3){1'b0}}, cfg_eff.border};
    x_ext  = {1'b0, pix_x};
    y_ext  = {1'b0, pix_y};
    w_ext  = {1'b0, meas_width};
    h_ext  = {1'b0, lim_height};
    lead   = (x_ext < b_ext) || (y_ext < b_ext);
    trail  = lim_valid && (((x_ext + b_ext) >= w_ext) || ((y_ext + b_ext) >= h_ext));
    border = (cfg_eff.border != 4'd0) && (lead || trail);
  end

  logic [7:0]  s_mag;
  logic        is_edge;
  logic [23:0] pix_nxt;

  always_comb begin
    s_mag   = pixel_in[23:16];
    is_edge = (s_mag >= cfg_eff.thr);
    pix_nxt = 24'h000000;
    if (de_in) begin
      if (cfg_eff.mode == MODE_PASS) begin
        pix_nxt = pixel_in;
      end else if (!border) begin
        case (cfg_eff.mode)
          MODE_MAG: pix_nxt = gray3(s_mag);
          MODE_THR: pix_nxt = is_edge ? 24'hFFFFFF : 24'h000000;
          MODE_OVL: pix_nxt = {(is_edge ? 8'hFF : 8'h00), pixel_in[15:0]};
          default:  pix_nxt = 24'h000000;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_out        <= 1'b0;
      h_sync_out    <= 1'b0;
      v_sync_out    <= 1'b0;
      pixel_out     <= 24'h000000;
      shadow.mode   <= MODE_PASS;
      shadow.thr    <= DEFAULT_THR;
      shadow.border <= 4'd0;
    end else begin
      de_out     <= de_in;
      h_sync_out <= h_sync_in;
      v_sync_out <= v_sync_in;
      pixel_out  <= pix_nxt;
      if (frame_start) shadow <= cfg_eff;
    end
  end

`ifdef SOBEL_CTRL_STATS_EN
  logic [23:0] edge_acc;
  logic        edge_hit;

  assign edge_hit = is_edge & ~border & de_in;

  // The pixel arriving with the vsync rise belongs to the new frame's count.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_acc   <= 24'd0;
      edge_count <= 24'd0;
    end else if (frame_start) begin
      edge_count <= edge_acc;
      edge_acc   <= {23'd0, edge_hit};
    end else if (edge_hit && (edge_acc != 24'hFFFFFF)) begin
      edge_acc <= edge_acc + 24'd1;
    end
  end
`else
  assign edge_count = 24'd0;
`endif

endmodule

// File: tb/tb_sobel_ctrl.sv
// Randomized scoreboard bench for sobel_ctrl: a frame-level model predicts every output cycle,
// a monitor on the falling edge pops and compares; status registers are checked at frame/line events.
module tb_sobel_ctrl;

`ifdef SOBEL_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        de_in, h_sync_in, v_sync_in;
  logic [23:0] pixel_in;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_thr;
  logic [3:0]  cfg_border;
  logic        de_out, h_sync_out, v_sync_out;
  logic [23:0] pixel_out;
  logic [11:0] meas_width, meas_height;
  logic [15:0] frame_cnt;
  logic [23:0] edge_count;

  always #5 clk = ~clk;

  sobel_ctrl dut (
    .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .pixel_in(pixel_in), .cfg_mode(cfg_mode), .cfg_thr(cfg_thr), .cfg_border(cfg_border),
    .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .pixel_out(pixel_out),
    .meas_width(meas_width), .meas_height(meas_height), .frame_cnt(frame_cnt),
    .edge_count(edge_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [26:0] exp_q[$];

  // Reference model state, kept in frame/line terms.
  int         m_width, m_height, lines_done, frames, edge_acc, edge_last, cur_w;
  bit         m_dv, pend_le;
  logic [1:0] sh_mode;
  logic [7:0] sh_thr;
  logic [3:0] sh_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    logic [26:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stream{de,hs,vs,pix}", {5'd0, de_out, h_sync_out, v_sync_out, pixel_out}, {5'd0, e});
      end
    end
  end

  function automatic bit is_border(input int x, input int y);
    int b;
    b = int'(sh_b);
    if (b == 0) return 1'b0;
    return (x < b) || (y < b) || (m_dv && ((x >= m_width - b) || (y >= m_height - b)));
  endfunction

  function automatic logic [23:0] gen_pix(input int sel, input int x, input int y);
    logic [23:0] p;
    p = 24'($urandom);
    if (sel == 1) begin
      case ($urandom_range(0, 2))
        0:       p[23:16] = 8'd63;
        1:       p[23:16] = 8'd64;
        default: p[23:16] = 8'($urandom);
      endcase
    end else if (sel == 2) begin
      if (x == 0 || y == 0 || x == 7 || y == 5) p[23:16] = 8'd255;
      else if ((x == y && x <= 4) || (x == 6 && y == 1)) p[23:16] = 8'd200;
      else p[23:16] = 8'd10;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_width = 0; m_height = 0; lines_done = 0; frames = 0;
    edge_acc = 0; edge_last = 0; m_dv = 1'b0; pend_le = 1'b0;
    sh_mode = 2'd0; sh_thr = 8'd64; sh_b = 4'd0;
  endtask

  task automatic step(input bit de, input bit hs, input bit vs, input bit fs, input logic [23:0] pix,
                      input int x, input logic [1:0] md, input logic [7:0] th, input logic [3:0] bd);
    logic [23:0] ep;
    bit le, bo, e;
    de_in = de; h_sync_in = hs; v_sync_in = vs; pixel_in = pix;
    cfg_mode = md; cfg_thr = th; cfg_border = bd;
    if (fs) begin
      sh_mode = md; sh_thr = th; sh_b = bd;
      m_dv = (m_width != 0) && (lines_done != 0);
      m_height = lines_done;
      lines_done = 0;
      frames++;
      edge_last = edge_acc;
      edge_acc = 0;
    end
    ep = 24'h0;
    if (de) begin
      bo = is_border(x, lines_done);
      e  = (pix[23:16] >= sh_thr);
      if (e && !bo) edge_acc++;
      if (sh_mode == 2'd0) ep = pix;
      else if (!bo) begin
        case (sh_mode)
          2'd1:    ep = {pix[23:16], pix[23:16], pix[23:16]};
          2'd2:    ep = e ? 24'hFFFFFF : 24'h000000;
          default: ep = {(e ? 8'hFF : 8'h00), pix[15:0]};
        endcase
      end
    end
    le = pend_le && !de;
    if (le) begin
      m_width = cur_w;
      lines_done++;
      pend_le = 1'b0;
    end
    @(posedge clk);
    exp_q.push_back({de, hs, vs, ep});
    #1;
    if (fs) begin
      check("frame_cnt", {16'd0, frame_cnt}, {16'd0, frames[15:0]});
      check("meas_height", {20'd0, meas_height}, m_height);
      check("edge_count", {8'd0, edge_count}, STATS ? edge_last : 0);
    end
    if (le) check("meas_width", {20'd0, meas_width}, m_width);
  endtask

  task automatic step_r(input bit de, input bit hs, input bit vs, input logic [23:0] pix, input int x);
    step(de, hs, vs, 1'b0, pix, x, 2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom));
  endtask

  task automatic run_frame(input int w, input int h, input logic [1:0] md, input logic [7:0] th,
                           input logic [3:0] bd, input bit vs_de, input int sel);
    cur_w = w;
    if (!vs_de) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 24'h0, 0, md, th, bd);
      step_r(1'b0, 1'b0, 1'b1, 24'h0, 0);
    end
    for (int y = 0; y < h; y++) begin
      if (!(vs_de && y == 0)) begin
        step_r(1'b0, 1'b1, 1'b0, 24'h0, 0);
        step_r(1'b0, 1'b0, 1'b0, 24'h0, 0);
      end
      for (int x = 0; x < w; x++) begin
        if (vs_de && y == 0 && x == 0) step(1'b1, 1'b0, 1'b1, 1'b1, gen_pix(sel, x, y), x, md, th, bd);
        else step_r(1'b1, 1'b0, 1'b0, gen_pix(sel, x, y), x);
      end
      pend_le = 1'b1;
    end
    repeat (3) step_r(1'b0, 1'b0, 1'b0, 24'h0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; pixel_in = 24'h0;
    cfg_mode = 2'd0; cfg_thr = 8'd0; cfg_border = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst de_out", {31'd0, de_out}, 0);
    check("rst syncs", {30'd0, h_sync_out, v_sync_out}, 0);
    check("rst pixel_out", {8'd0, pixel_out}, 0);
    check("rst meas_width", {20'd0, meas_width}, 0);
    check("rst meas_height", {20'd0, meas_height}, 0);
    check("rst frame_cnt", {16'd0, frame_cnt}, 0);
    check("rst edge_count", {8'd0, edge_count}, 0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    do_reset();
    run_frame(8, 6, 2'd0, 8'd64, 4'd0, 1'b0, 0);   // PASS, first frame: no trailing border yet
    run_frame(8, 6, 2'd1, 8'd30, 4'd1, 1'b0, 0);   // MAG, border 1
    run_frame(8, 6, 2'd2, 8'd64, 4'd1, 1'b0, 1);   // THR around S=63/64
    run_frame(8, 6, 2'd3, 8'd128, 4'd2, 1'b1, 0);  // OVL, vsync rises with first pixel
    run_frame(8, 6, 2'd2, 8'd100, 4'd1, 1'b0, 2);  // five interior edges
    run_frame(8, 6, 2'd0, 8'd64, 4'd1, 1'b0, 0);   // its start publishes edge_count

    // Reset in the middle of a line, then recover with a clean frame.
    step(1'b0, 1'b0, 1'b1, 1'b1, 24'h0, 0, 2'd1, 8'd50, 4'd1);
    step_r(1'b0, 1'b0, 1'b1, 24'h0, 0);
    step_r(1'b0, 1'b1, 1'b0, 24'h0, 0);
    for (int x = 0; x < 4; x++) step_r(1'b1, 1'b0, 1'b0, gen_pix(0, x, 0), x);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      run_frame($urandom_range(3, 12), $urandom_range(2, 8), 2'($urandom_range(0, 3)), 8'($urandom),
                4'($urandom_range(0, 5)), (i > 0) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1));
    end
    run_frame(4, 2, 2'd0, 8'd64, 4'd0, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
